rhs_spi_master_gen: RTL and testbench
=====================================

RHS_SPI_MASTER_GEN -- requirements
Module: rhs_spi_master_gen

Interface
REQ-001 Parameter WORD_W, default 32, meaning bits per CS-low frame; legal minimum 2.
REQ-002 Parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period; legal minimum 1.
REQ-003 Parameter CS_GAP, default 16, meaning minimum clk cycles CS held high between frames; legal minimum 1.
REQ-004 Parameter MAX_DELAY, default 15, meaning largest MISO sample delay in clk cycles.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  frame request.
REQ-008 in_ready  out  1  high only in IDLE; a frame is accepted on a cycle with in_valid and in_ready both high.
REQ-009 data_in  in  WORD_W  MOSI word, MSB first, latched on accept.
REQ-010 miso_delay  in  clog2(MAX_DELAY+1)  MISO sample delay, latched on accept (RHS_SPI_MISO_DELAY_EN only).
REQ-011 out_valid  out  1  one-cycle pulse when a frame completes.
REQ-012 data_out  out  WORD_W  captured MISO word, MSB first; holds until the next completion.
REQ-013 busy  out  1  high from the cycle after accept until the cycle out_valid pulses, inclusive.
REQ-014 SCLK, MOSI, CS  out  1 each; MISO  in  1; SPI mode 0 (CPOL=0, CPHA=0).

Function
REQ-015 States: IDLE, SHIFT, TRAIL, GAP, WAIT.
- IDLE -> SHIFT on accept.
- SHIFT -> TRAIL after last bit.
- TRAIL -> GAP after CLK_DIV cycles.
- GAP -> WAIT after CS_GAP cycles.
- WAIT -> IDLE when all WORD_W samples are captured; out_valid pulses on this transition.
REQ-016 CS is low in SHIFT and TRAIL and high in all other states; CS falls on the first clk edge after accept.
REQ-017 SHIFT bit i (i = WORD_W-1 down to 0): SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-018 MOSI presents bit i from the first low cycle of bit i; MOSI changes only while SCLK is low or on the cycle SCLK falls.
REQ-019 In TRAIL, SCLK is 0 and MOSI holds the last bit; in IDLE and GAP, MOSI is 0.
REQ-020 Nominal sample point of bit i is the first clk cycle with SCLK high for that bit; MISO is captured miso_delay cycles after the nominal point.
REQ-021 Captured bits shift in MSB first; delayed samples landing in TRAIL, GAP or WAIT are still captured.
REQ-022 With zero delay, frame length from accept to out_valid is 2*CLK_DIV*WORD_W + CLK_DIV + CS_GAP + 1 cycles; WAIT is then skipped in zero cycles.
REQ-023 in_valid while busy is ignored; no queueing.
REQ-024 Back-to-back frames: with in_valid held high, CS stays high for exactly CS_GAP + 1 cycles between frames (zero delay).
REQ-025 data_in and miso_delay changes after accept have no effect on the frame in flight.

Reset
REQ-026 On rst, the next edge forces IDLE with: SCLK=0, CS=1, MOSI=0, out_valid=0, busy=0, data_out=0, in_ready=1.
REQ-027 Reset mid-frame aborts immediately: no out_valid, pending delayed samples discarded, and CS high on the next edge.

Configuration
REQ-028 Macro RHS_SPI_MISO_DELAY_EN defined: miso_delay port present and sample delay per REQ-020; values above MAX_DELAY saturate to MAX_DELAY.
REQ-029 Macro RHS_SPI_MISO_DELAY_EN undefined: miso_delay port absent, delay fixed at 0, WAIT state and delay pipeline removed.

Verification
REQ-030 Defaults, MOSI looped to MISO, delay 0, data_in=32'hFEEDBEEA -> data_out=32'hFEEDBEEA; out_valid 147 cycles after accept; 32 SCLK rising edges counted.
REQ-031 Slave model returns 32'hDEADBEEF with MISO lagging 3 clk cycles, miso_delay=3 -> data_out=32'hDEADBEEF; with miso_delay=0 -> data_out differs.
REQ-032 CLK_DIV=1, miso_delay=15 -> out_valid only after the 32nd delayed sample; busy stays high through WAIT; data_out correct.
REQ-033 in_valid held high with two words 32'h12345678, 32'h9ABCDEF0 -> two out_valid pulses; CS high gap 17 cycles; pulses on in_valid during busy ignored.
REQ-034 rst asserted one cycle during bit 10 -> CS=1 and SCLK=0 next edge, no out_valid; a following frame with 32'hA5A5A5A5 returns 32'hA5A5A5A5.

Source files
------------

// File: rtl/rhs_spi_master_gen.sv
// SPI mode-0 master: one WORD_W-bit CS-low frame per accepted request, MSB first.
// Optional RHS_SPI_MISO_DELAY_EN adds a per-frame MISO sample delay (WAIT state + strobe pipeline).
module rhs_spi_master_gen #(
    parameter int WORD_W    = 32,
    parameter int CLK_DIV   = 2,
    parameter int CS_GAP    = 16,
    parameter int MAX_DELAY = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_W-1:0]                data_in,
`ifdef RHS_SPI_MISO_DELAY_EN
    input  logic [$clog2(MAX_DELAY+1)-1:0]   miso_delay,
`endif
    output logic                             out_valid,
    output logic [WORD_W-1:0]                data_out,
    output logic                             busy,
    output logic                             sclk,
    output logic                             mosi,
    output logic                             cs,
    input  logic                             miso
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(WORD_W);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        TRAIL = 3'd2,
        GAP   = 3'd3
`ifdef RHS_SPI_MISO_DELAY_EN
        ,WAIT = 3'd4
`endif
    } state_t;

    state_t            state_r, state_n;
    logic [CW-1:0]     cnt_r, cnt_n;
    logic [BW-1:0]     bit_r, bit_n;
    logic              sclk_r, sclk_n, cs_r, cs_n, mosi_r, mosi_n;
    logic [WORD_W-1:0] tx_r, tx_n, rx_r, rx_n, data_out_r, data_out_n;
    logic              out_valid_r, out_valid_n, busy_r, busy_n, ready_r, ready_n;
    logic              nom_s, cap_s, done_s;

`ifdef RHS_SPI_MISO_DELAY_EN
    localparam int DW = $clog2(MAX_DELAY + 1);
    localparam int PW = (MAX_DELAY > 0) ? MAX_DELAY : 1;
    logic [DW-1:0]     dly_r, dly_n, dly_sat_s;
    logic [PW-1:0]     pipe_r, pipe_n;
    logic [BW:0]       cap_r, cap_n;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        bit_n       = bit_r;
        sclk_n      = sclk_r;
        cs_n        = cs_r;
        mosi_n      = mosi_r;
        tx_n        = tx_r;
        rx_n        = rx_r;
        data_out_n  = data_out_r;
        out_valid_n = 1'b0;
        busy_n      = busy_r;
        ready_n     = ready_r;
        nom_s       = (state_r == SHIFT) && sclk_r && (cnt_r == {CW{1'b0}});

`ifdef RHS_SPI_MISO_DELAY_EN
        dly_n  = dly_r;
        pipe_n = (pipe_r << 1) | PW'(nom_s);
        if ({1'b0, miso_delay} > (DW+1)'(MAX_DELAY)) begin
            dly_sat_s = DW'(MAX_DELAY);
        end else begin
            dly_sat_s = miso_delay;
        end
        // Tap the strobe pipeline at the latched delay; delay 0 uses the nominal strobe.
        cap_s = 1'b0;
        if (dly_r == {DW{1'b0}}) begin
            cap_s = nom_s;
        end else begin
            for (int i = 0; i < PW; i++) begin
                if (dly_r == DW'(i + 1)) begin
                    cap_s = pipe_r[i];
                end else begin
                    cap_s = cap_s;
                end
            end
        end
        if (cap_s) begin
            cap_n = cap_r + 1'b1;
        end else begin
            cap_n = cap_r;
        end
        done_s = (cap_r == (BW+1)'(WORD_W)) || (cap_s && (cap_r == (BW+1)'(WORD_W - 1)));
`else
        cap_s  = nom_s;
        done_s = 1'b1;
`endif

        if (cap_s) begin
            rx_n = {rx_r[WORD_W-2:0], miso};
        end else begin
            rx_n = rx_r;
        end

        case (state_r)
            IDLE: begin
                busy_n  = 1'b0;
                cs_n    = 1'b1;
                sclk_n  = 1'b0;
                mosi_n  = 1'b0;
                ready_n = 1'b1;
                if (in_valid && ready_r) begin
                    state_n = SHIFT;
                    cs_n    = 1'b0;
                    mosi_n  = data_in[WORD_W-1];
                    tx_n    = data_in;
                    cnt_n   = {CW{1'b0}};
                    bit_n   = BIT_MSB;
                    busy_n  = 1'b1;
                    ready_n = 1'b0;
`ifdef RHS_SPI_MISO_DELAY_EN
                    dly_n   = dly_sat_s;
                    cap_n   = {(BW+1){1'b0}};
                    pipe_n  = {PW{1'b0}};
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_n = {CW{1'b0}};
                    if (!sclk_r) begin
                        sclk_n = 1'b1;
                    end else begin
                        // Falling edge: advance to the next bit, or leave SHIFT after bit 0.
                        sclk_n = 1'b0;
                        if (bit_r == {BW{1'b0}}) begin
                            state_n = TRAIL;
                        end else begin
                            bit_n  = bit_r - 1'b1;
                            tx_n   = tx_r << 1;
                            mosi_n = tx_r[WORD_W-2];
                        end
                    end
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            TRAIL: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_n   = {CW{1'b0}};
                    state_n = GAP;
                    cs_n    = 1'b1;
                    mosi_n  = 1'b0;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_n = {CW{1'b0}};
                    if (done_s) begin
                        state_n     = IDLE;
                        out_valid_n = 1'b1;
                        ready_n     = 1'b1;
                        data_out_n  = rx_n;
                    end else begin
`ifdef RHS_SPI_MISO_DELAY_EN
                        state_n = WAIT;
`else
                        state_n = GAP;
`endif
                    end
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
`ifdef RHS_SPI_MISO_DELAY_EN
            WAIT: begin
                if (done_s) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b1;
                    ready_n     = 1'b1;
                    data_out_n  = rx_n;
                end else begin
                    state_n = WAIT;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                cs_n    = 1'b1;
                sclk_n  = 1'b0;
                mosi_n  = 1'b0;
                busy_n  = 1'b0;
                ready_n = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            bit_r       <= {BW{1'b0}};
            sclk_r      <= 1'b0;
            cs_r        <= 1'b1;
            mosi_r      <= 1'b0;
            tx_r        <= {WORD_W{1'b0}};
            rx_r        <= {WORD_W{1'b0}};
            data_out_r  <= {WORD_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
`ifdef RHS_SPI_MISO_DELAY_EN
            dly_r       <= {DW{1'b0}};
            pipe_r      <= {PW{1'b0}};
            cap_r       <= {(BW+1){1'b0}};
`endif
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            bit_r       <= bit_n;
            sclk_r      <= sclk_n;
            cs_r        <= cs_n;
            mosi_r      <= mosi_n;
            tx_r        <= tx_n;
            rx_r        <= rx_n;
            data_out_r  <= data_out_n;
            out_valid_r <= out_valid_n;
            busy_r      <= busy_n;
            ready_r     <= ready_n;
`ifdef RHS_SPI_MISO_DELAY_EN
            dly_r       <= dly_n;
            pipe_r      <= pipe_n;
            cap_r       <= cap_n;
`endif
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
    assign busy      = busy_r;
    assign sclk      = sclk_r;
    assign mosi      = mosi_r;
    assign cs        = cs_r;

endmodule

// File: tb/tb_rhs_spi_master_gen.sv
// Directed bench for rhs_spi_master_gen: table of loopback frames plus hand-written corner sequences.
module tb_rhs_spi_master_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, busy, sclk, mosi, cs, miso;
    logic [31:0] data_in, data_out;
    logic [2:0]  lag_a = 3'b000;
    int          mode;
    int          checks = 0;
    int          passes = 0;

    // Slave models: echo, inverted echo, echo lagging three clk cycles.
    always @(posedge clk) lag_a <= {lag_a[1:0], mosi};
    assign miso = (mode == 0) ? mosi : (mode == 1) ? ~mosi : lag_a[2];

`ifdef RHS_SPI_MISO_DELAY_EN
    logic [3:0]  miso_delay;
`endif

    rhs_spi_master_gen dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
`ifdef RHS_SPI_MISO_DELAY_EN
        .miso_delay(miso_delay),
`endif
        .out_valid(out_valid), .data_out(data_out), .busy(busy),
        .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso)
    );

`ifdef RHS_SPI_MISO_DELAY_EN
    logic        in_valid_b, in_ready_b, out_valid_b, busy_b, sclk_b, mosi_b, cs_b, miso_b;
    logic [31:0] data_in_b, data_out_b;
    logic [3:0]  miso_delay_b;
    logic [14:0] lag_b = 15'd0;
    always @(posedge clk) lag_b <= {lag_b[13:0], mosi_b};
    assign miso_b = lag_b[14];

    rhs_spi_master_gen #(.CLK_DIV(1), .CS_GAP(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .data_in(data_in_b),
        .miso_delay(miso_delay_b),
        .out_valid(out_valid_b), .data_out(data_out_b), .busy(busy_b),
        .sclk(sclk_b), .mosi(mosi_b), .cs(cs_b), .miso(miso_b)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_frame(input string name, input logic [31:0] din, input int dly,
                             input logic [31:0] exp, input int exp_lat);
        int   cyc, rises, csl;
        logic prev;
        logic busy_ok;
        @(negedge clk);
        data_in  = din;
        in_valid = 1'b1;
`ifdef RHS_SPI_MISO_DELAY_EN
        miso_delay = dly[3:0];
`endif
        check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = ~din;
`ifdef RHS_SPI_MISO_DELAY_EN
        miso_delay = 4'd7;
`endif
        cyc = 1; rises = 0; prev = 1'b0; busy_ok = 1'b1; csl = 0;
        while (!out_valid && cyc < 400) begin
            if (sclk && !prev) rises++;
            prev = sclk;
            if (!busy) busy_ok = 1'b0;
            if (!cs) csl++;
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_data"}, data_out, exp);
        check({name, "_sclk_rises"}, rises, 32'd32);
        check({name, "_cs_low"}, csl, 32'd130);
        check({name, "_busy"}, {31'd0, busy_ok & busy}, 32'd1);
        @(negedge clk);
        check({name, "_pulse_end"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] din;
        int          mode;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[5];
    int          pulses, gap, cyc, p1, p2, extra;
    logic        seen_low, gap_done, busy_ok, wait_seen;
    logic [31:0] d1, d2;

    initial begin
        vecs[0] = '{32'hFEEDBEEA, 0, 32'hFEEDBEEA};
        vecs[1] = '{32'h00000000, 1, 32'hFFFFFFFF};
        vecs[2] = '{32'h80000001, 0, 32'h80000001};
        vecs[3] = '{32'hFFFFFFFF, 1, 32'h00000000};
        vecs[4] = '{32'h0F0F1234, 1, 32'hF0F0EDCB};

        rst = 1'b1; in_valid = 1'b0; data_in = 32'd0; mode = 0;
`ifdef RHS_SPI_MISO_DELAY_EN
        miso_delay = 4'd0; in_valid_b = 1'b0; data_in_b = 32'd0; miso_delay_b = 4'd0;
`endif
        repeat (3) @(negedge clk);
        check("reset_ctrl", {26'd0, sclk, cs, mosi, out_valid, busy, in_ready}, 32'b010001);
        check("reset_data", data_out, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            run_frame($sformatf("vec%0d", i), vecs[i].din, 0, vecs[i].exp, 147);
        end
        mode = 0;

        // Back-to-back frames with in_valid held high, plus an ignored request while busy.
        @(negedge clk);
        data_in = 32'h12345678; in_valid = 1'b1;
        pulses = 0; gap = 0; seen_low = 1'b0; gap_done = 1'b0; cyc = 0; p1 = 0; p2 = 0;
        d1 = 32'd0; d2 = 32'd0;
        while (pulses < 2 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) data_in = 32'h9ABCDEF0;
            if (pulses == 1 && cyc == p1 + 1) in_valid = 1'b0;
            if (pulses == 1 && cyc == p1 + 30) begin in_valid = 1'b1; data_in = 32'h0; end
            if (pulses == 1 && cyc == p1 + 31) in_valid = 1'b0;
            if (!cs) begin
                seen_low = 1'b1;
                if (gap > 0) gap_done = 1'b1;
            end else if (seen_low && !gap_done) begin
                gap++;
            end
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin d1 = data_out; p1 = cyc; end
                else begin d2 = data_out; p2 = cyc; end
            end
        end
        in_valid = 1'b0;
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("b2b_pulses", pulses, 32'd2);
        check("b2b_first_latency", p1, 32'd147);
        check("b2b_word0", d1, 32'h12345678);
        check("b2b_word1", d2, 32'h9ABCDEF0);
        check("b2b_spacing", p2 - p1, 32'd147);
        check("b2b_cs_gap", gap, 32'd17);
        check("b2b_no_extra", extra, 32'd0);

        // Reset during bit 10 aborts the frame.
        @(negedge clk);
        data_in = 32'h13579BDF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (85) @(negedge clk);
        check("mid_in_frame", {31'd0, cs}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ctrl", {27'd0, cs, sclk, busy, in_ready, mosi}, 32'b10010);
        check("mid_rst_data", data_out, 32'd0);
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("mid_rst_no_valid", extra, 32'd0);
        run_frame("after_rst", 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 147);

`ifdef RHS_SPI_MISO_DELAY_EN
        mode = 2;
        run_frame("lag3_d3", 32'hDEADBEEF, 3, 32'hDEADBEEF, 147);
        run_frame("lag3_d0", 32'hDEADBEEF, 0, 32'h6F56DF77, 147);
        check("lag3_d0_differs", {31'd0, data_out != 32'hDEADBEEF}, 32'd1);
        mode = 0;

        // CLK_DIV=1, CS_GAP=2, delay 15: last sample lands in WAIT.
        @(negedge clk);
        data_in_b = 32'hC3A50F96; in_valid_b = 1'b1; miso_delay_b = 4'd15;
        @(negedge clk);
        in_valid_b = 1'b0; miso_delay_b = 4'd0; data_in_b = 32'd0;
        cyc = 1; busy_ok = 1'b1; wait_seen = 1'b0;
        while (!out_valid_b && cyc < 300) begin
            if (!busy_b) busy_ok = 1'b0;
            if (cyc > 67 && cs_b && busy_b) wait_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("dly15_latency", cyc, 32'd80);
        check("dly15_data", data_out_b, 32'hC3A50F96);
        check("dly15_busy", {31'd0, busy_ok & busy_b}, 32'd1);
        check("dly15_wait", {31'd0, wait_seen}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
